// File: rtl/param_reg_pipe.sv
// param_reg_pipe: byte-merging shadow register feeding a DEPTH-stage valid/ready pipeline with flush.
module param_reg_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int LANES = (WIDTH + 7) / 8,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LANES-1:0] in_be,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OW-1:0]    occupancy
);
  logic [DEPTH-1:0] v_q, v_d, rdy;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] shadow_q, shadow_d, merged;
  logic acc;
  // a stage is ready unless it and every stage after it are full and the consumer stalls
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign rdy[g] = out_ready | ~&v_q[DEPTH-1:g];
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_mrg
    assign merged[g] = in_be[g/8] ? in_data[g] : shadow_q[g];
  end
  assign in_ready  = rdy[0] & ~flush & ~reset;
  assign acc       = in_valid & in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  always_comb begin
    shadow_d  = acc ? merged : shadow_q;
    v_d       = v_q;
    data_d    = data_q;
    v_d[0]    = ~flush & (rdy[0] ? acc : v_q[0]);
    data_d[0] = acc ? merged : data_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]    = ~flush & (rdy[i] ? v_q[i-1] : v_q[i]);
      data_d[i] = (rdy[i] & v_q[i-1]) ? data_q[i-1] : data_q[i];
    end
  end
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(v_q[i]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q      <= '0;
      shadow_q <= RST_VAL;
      data_q   <= '{default: RST_VAL};
    end else begin
      v_q      <= v_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  end
endmodule

// File: tb/tb_param_reg_pipe.sv
// tb_param_reg_pipe: drives a 32b/depth-2 and a 9b/depth-4 pipe with shared stimulus, checked against a queue model.
module tb_param_reg_pipe;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic [3:0] in_be = '0;
  logic a_ir, a_ov, b_ir, b_ov;
  logic [31:0] a_od;
  logic [8:0] b_od;
  logic [1:0] a_occ;
  logic [2:0] b_occ;
  param_reg_pipe #(.WIDTH(32), .DEPTH(2), .RST_VAL(32'hA5A5_A5A5)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .in_be(in_be), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_od), .occupancy(a_occ));
  param_reg_pipe #(.WIDTH(9), .DEPTH(4), .RST_VAL(9'h000)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data[8:0]), .in_be(in_be[1:0]), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_od), .occupancy(b_occ));
  logic obs_ir [2];
  logic obs_ov [2];
  logic [31:0] obs_od [2];
  logic [31:0] obs_occ [2];
  always_comb begin
    obs_ir[0] = a_ir;
    obs_ir[1] = b_ir;
    obs_ov[0] = a_ov;
    obs_ov[1] = b_ov;
    obs_od[0] = a_od;
    obs_od[1] = {23'b0, b_od};
    obs_occ[0] = {30'b0, a_occ};
    obs_occ[1] = {29'b0, b_occ};
  end
  int n_cmp = 0, n_err = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  int dep [2] = '{2, 4};
  logic [31:0] wmask [2] = '{32'hFFFF_FFFF, 32'h0000_01FF};
  logic [31:0] rstv [2] = '{32'hA5A5_A5A5, 32'h0};
  logic [31:0] shd [2];
  logic [31:0] qd [2][8];
  int qt [2][8];
  int qh [2], qn [2];
  int cyc = 0;
  logic [31:0] lga [$];
  logic [31:0] lgb [$];
  function automatic logic [31:0] merge(int d, logic [31:0] dat, logic [3:0] be);
    logic [31:0] bm;
    bm = '0;
    for (int k = 0; k < 4; k++) if (be[k]) bm = bm | (32'hFF << (8 * k));
    return ((dat & bm) | (shd[d] & ~bm)) & wmask[d];
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      shd[d] = rstv[d];
      qn[d] = 0;
      qh[d] = 0;
    end
  endtask
  // one cycle: check outputs at negedge, then advance the model across the posedge
  task automatic step();
    bit acc [2];
    bit emi [2];
    logic [31:0] m;
    int c;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic xr, xv;
      string p;
      p = d == 1 ? "b" : "a";
      xr = !reset && !flush && (qn[d] < dep[d] || out_ready);
      xv = qn[d] > 0 && (cyc - qt[d][qh[d]]) >= dep[d];
      chk({p, "_in_ready"}, 32'(obs_ir[d]), 32'(xr));
      chk({p, "_out_valid"}, 32'(obs_ov[d]), 32'(xv));
      chk({p, "_occupancy"}, obs_occ[d], 32'(qn[d]));
      if (xv) chk({p, "_out_data"}, obs_od[d], qd[d][qh[d]]);
      acc[d] = in_valid && xr;
      emi[d] = xv && out_ready;
      if (emi[d]) begin
        if (d == 0) lga.push_back(obs_od[0]);
        else lgb.push_back(obs_od[1]);
      end
    end
    @(posedge clk);
    #1;
    c = cyc;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (emi[d]) begin
        qh[d] = (qh[d] + 1) % 8;
        qn[d]--;
      end
      if (flush) qn[d] = 0;
      if (acc[d]) begin
        m = merge(d, in_data, in_be);
        shd[d] = m;
        qd[d][(qh[d] + qn[d]) % 8] = m;
        qt[d][(qh[d] + qn[d]) % 8] = c;
        qn[d]++;
      end
    end
  endtask
  task automatic beat(logic [31:0] dat, logic [3:0] be);
    in_valid = 1;
    in_data = dat;
    in_be = be;
    step();
    in_valid = 0;
  endtask
  task automatic chk_reset_state(string tag);
    chk({tag, "_a_out_valid"}, 32'(a_ov), 32'd0);
    chk({tag, "_a_out_data"}, a_od, 32'hA5A5_A5A5);
    chk({tag, "_a_occupancy"}, 32'(a_occ), 32'd0);
    chk({tag, "_a_in_ready"}, 32'(a_ir), 32'd0);
    chk({tag, "_b_out_valid"}, 32'(b_ov), 32'd0);
    chk({tag, "_b_out_data"}, 32'(b_od), 32'd0);
    chk({tag, "_b_occupancy"}, 32'(b_occ), 32'd0);
    chk({tag, "_b_in_ready"}, 32'(b_ir), 32'd0);
  endtask
  // asynchronous assertion away from the edge; state must clear before any clock
  task automatic do_reset();
    in_valid = 0;
    flush = 0;
    @(posedge clk);
    #2 reset = 1;
    #1 chk_reset_state("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_state("por");
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    out_ready = 1;
    lga.delete();
    beat(32'hDEAD_BEEF, 4'b1111);
    beat(32'h0000_00FF, 4'b0001);
    beat(32'h1234_0000, 4'b1100);
    repeat (5) step();
    chk("merge_count", 32'(lga.size()), 32'd3);
    chk("merge_0", lga[0], 32'hDEAD_BEEF);
    chk("merge_1", lga[1], 32'hDEAD_BEFF);
    chk("merge_2", lga[2], 32'h1234_BEFF);
    beat(32'h1111_1111, 4'b1111);
    beat(32'h2222_2222, 4'b1111);
    do_reset();
    lga.delete();
    lgb.delete();
    beat(32'h1122_3344, 4'b0001);
    repeat (5) step();
    chk("rst_merge_a", lga[0], 32'hA5A5_A544);
    chk("rst_merge_b", lgb[0], 32'h0000_0044);
    out_ready = 0;
    in_valid = 1;
    in_be = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'h10 + 32'(i);
      step();
    end
    in_valid = 0;
    chk("bp_b_occupancy", 32'(b_occ), 32'd4);
    chk("bp_b_in_ready", 32'(b_ir), 32'd0);
    chk("bp_a_occupancy", 32'(a_occ), 32'd2);
    lga.delete();
    lgb.delete();
    out_ready = 1;
    in_valid = 1;
    in_data = 32'h1AB;
    #1;
    chk("pass_a_in_ready", 32'(a_ir), 32'd1);
    chk("pass_b_in_ready", 32'(b_ir), 32'd1);
    step();
    in_valid = 0;
    chk("pass_a_occupancy", 32'(a_occ), 32'd2);
    chk("pass_b_occupancy", 32'(b_occ), 32'd4);
    repeat (6) step();
    chk("drain_b_count", 32'(lgb.size()), 32'd5);
    chk("drain_b_0", lgb[0], 32'h10);
    chk("drain_b_1", lgb[1], 32'h11);
    chk("drain_b_2", lgb[2], 32'h12);
    chk("drain_b_3", lgb[3], 32'h13);
    chk("drain_b_4", lgb[4], 32'h1AB);
    chk("drain_a_count", 32'(lga.size()), 32'd3);
    chk("drain_a_2", lga[2], 32'h1AB);
    out_ready = 0;
    beat(32'h0A1, 4'b1111);
    beat(32'h0B2, 4'b1111);
    beat(32'h1C3, 4'b1111);
    chk("fl_b_occupancy", 32'(b_occ), 32'd3);
    flush = 1;
    in_valid = 1;
    in_data = $urandom;
    #1;
    chk("fl_b_in_ready", 32'(b_ir), 32'd0);
    step();
    flush = 0;
    in_valid = 0;
    chk("fl_b_occ_after", 32'(b_occ), 32'd0);
    chk("fl_a_occ_after", 32'(a_occ), 32'd0);
    lga.delete();
    lgb.delete();
    out_ready = 1;
    beat(32'h55, 4'b0000);
    repeat (5) step();
    chk("fl_b_shadow", lgb[0], 32'h1C3);
    chk("fl_a_shadow", lga[0], 32'h0B2);
    lgb.delete();
    beat(32'h0FF, 4'b0011);
    beat(32'h100, 4'b0010);
    repeat (5) step();
    chk("odd_0", lgb[0], 32'h0FF);
    chk("odd_1", lgb[1], 32'h1FF);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
      in_be = 4'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 29) == 0;
      step();
    end
    flush = 0;
    in_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
